// File: rtl/cpu_wb_arbiter.sv
// Register-file write-port arbiter: shares one write port between the main
// pipeline and a small buffer of long-latency unit results, with a starvation
// counter that forces the pipeline to yield one cycle to the oldest buffered result.
module cpu_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  output logic        pipe_ready_o,
  input  logic        unit_valid_i,
  input  logic [4:0]  unit_waddr_i,
  input  logic [31:0] unit_wdata_i,
  output logic        unit_ready_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [36:0]       mem_q [FIFO_DEPTH];
  logic              we_q, we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              pipe_gnt, fifo_gnt, push, pop;
  logic [4:0]        head_waddr;
  logic [31:0]       head_wdata;

  assign head_waddr = mem_q[rd_ptr_q][36:32];
  assign head_wdata = mem_q[rd_ptr_q][31:0];

  // Grant selection, FIFO bookkeeping, starvation counter and output staging.
  always_comb begin
    pipe_gnt = 1'b0;
    fifo_gnt = 1'b0;
    state_d  = state_q;

    pipe_ready_o = rst && (state_q == StNormal);
    // FORCE always pops (head guaranteed valid), so a full buffer can still take
    // a result that cycle; decided from registered state only.
    unit_ready_o = rst && ((count_q != CntFull) || (state_q == StForce));

    unique case (state_q)
      StNormal: begin
        if (pipe_valid_i)          pipe_gnt = 1'b1;
        else if (count_q != '0)    fifo_gnt = 1'b1;
      end
      StForce: begin
        fifo_gnt = (count_q != '0);
        state_d  = StNormal;
      end
      default: state_d = StNormal;
    endcase

    push = unit_valid_i && unit_ready_o;
    pop  = fifo_gnt;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    wait_d = wait_q;
    if ((count_q == '0) || fifo_gnt) wait_d = '0;
    else if (wait_q != WaitMax)      wait_d = wait_q + WaitW'(1);

    if ((state_q == StNormal) && !fifo_gnt && (count_q != '0) && (wait_d == WaitMax)) begin
      state_d = StForce;
    end

    // Writes to r0 still complete the handshake but never strobe the port.
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_gnt && (pipe_waddr_i != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = pipe_waddr_i;
      wdata_d = pipe_wdata_i;
    end else if (fifo_gnt && (head_waddr != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = head_waddr;
      wdata_d = head_wdata;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StNormal;
      wait_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Buffer storage; contents are don't-care until a push marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {unit_waddr_i, unit_wdata_i};
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter: inputs change 1 ns after a rising edge,
// registered outputs are checked in that same window.
module tb_cpu_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid_i;
  logic [4:0]  pipe_waddr_i;
  logic [31:0] pipe_wdata_i;
  logic        pipe_ready_o;
  logic        unit_valid_i;
  logic [4:0]  unit_waddr_i;
  logic [31:0] unit_wdata_i;
  logic        unit_ready_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int n_checks = 0;
  int n_errors = 0;

  cpu_wb_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid_i (pipe_valid_i),
    .pipe_waddr_i (pipe_waddr_i),
    .pipe_wdata_i (pipe_wdata_i),
    .pipe_ready_o (pipe_ready_o),
    .unit_valid_i (unit_valid_i),
    .unit_waddr_i (unit_waddr_i),
    .unit_wdata_i (unit_wdata_i),
    .unit_ready_o (unit_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
    check_eq({tag, "_we"}, 32'(we_o), 32'(we));
    check_eq({tag, "_addr"}, 32'(waddr_o), 32'(a));
    check_eq({tag, "_data"}, wdata_o, d);
  endtask

  initial begin
    rst = 1'b0;
    pipe_valid_i = 1'b0; pipe_waddr_i = '0; pipe_wdata_i = '0;
    unit_valid_i = 1'b0; unit_waddr_i = '0; unit_wdata_i = '0;

    // Reset state
    #3;
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check_eq("rst_prdy", 32'(pipe_ready_o), 32'd0);
    check_eq("rst_urdy", 32'(unit_ready_o), 32'd0);
    step(); step();
    rst = 1'b1;
    #1;
    check_eq("rel_prdy", 32'(pipe_ready_o), 32'd1);
    check_eq("rel_urdy", 32'(unit_ready_o), 32'd1);

    // Pipeline-only write
    pipe_valid_i = 1'b1; pipe_waddr_i = 5'd5; pipe_wdata_i = 32'hDEADBEEF;
    step();
    pipe_valid_i = 1'b0;
    check_wr("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check_wr("pipe_idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // Unit result with idle pipeline: push, grant next cycle, write one later
    unit_valid_i = 1'b1; unit_waddr_i = 5'd3; unit_wdata_i = 32'h12;
    check_eq("unit_urdy0", 32'(unit_ready_o), 32'd1);
    step();
    unit_valid_i = 1'b0;
    check_eq("unit_we_push", 32'(we_o), 32'd0);
    check_eq("unit_urdy1", 32'(unit_ready_o), 32'd1);
    step();
    check_wr("unit", 1'b1, 5'd3, 32'h12);
    step();
    check_eq("unit_idle_we", 32'(we_o), 32'd0);

    // Starvation: pipeline busy, one buffered result forces a yield
    pipe_valid_i = 1'b1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'h100;
    unit_valid_i = 1'b1; unit_waddr_i = 5'd9; unit_wdata_i = 32'hAA;
    step();
    unit_valid_i = 1'b0;
    check_wr("st_c0", 1'b1, 5'd7, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      pipe_wdata_i = 32'h100 + 32'(i);
      check_eq("st_prdy", 32'(pipe_ready_o), 32'd1);
      step();
      check_wr("st_pipe", 1'b1, 5'd7, 32'h100 + 32'(i));
    end
    pipe_wdata_i = 32'h105;
    check_eq("st_force_prdy", 32'(pipe_ready_o), 32'd0);
    step();
    check_wr("st_force", 1'b1, 5'd9, 32'hAA);
    check_eq("st_resume_prdy", 32'(pipe_ready_o), 32'd1);
    step();
    pipe_valid_i = 1'b0;
    check_wr("st_resume", 1'b1, 5'd7, 32'h105);
    step();

    // Full buffer: two pushes behind a busy pipeline, push during FORCE pop
    pipe_valid_i = 1'b1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'h300;
    unit_valid_i = 1'b1; unit_waddr_i = 5'd10; unit_wdata_i = 32'hB0;
    step();
    unit_waddr_i = 5'd11; unit_wdata_i = 32'hB1;
    check_eq("full_urdy1", 32'(unit_ready_o), 32'd1);
    step();
    unit_waddr_i = 5'd12; unit_wdata_i = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      check_eq("full_urdy0", 32'(unit_ready_o), 32'd0);
      step();
    end
    check_eq("full_force_prdy", 32'(pipe_ready_o), 32'd0);
    step();
    unit_valid_i = 1'b0;
    check_wr("full_pop", 1'b1, 5'd10, 32'hB0);
    check_eq("full_cnt_kept", 32'(unit_ready_o), 32'd0);
    step();
    pipe_valid_i = 1'b0;
    check_wr("full_pipe", 1'b1, 5'd7, 32'h300);
    step();
    check_wr("full_d1", 1'b1, 5'd11, 32'hB1);
    step();
    check_wr("full_d2", 1'b1, 5'd12, 32'hB2);
    step();
    check_eq("full_empty_we", 32'(we_o), 32'd0);
    check_eq("full_empty_urdy", 32'(unit_ready_o), 32'd1);

    // Zero destination: accepted, no write strobe, address/data held
    pipe_valid_i = 1'b1; pipe_waddr_i = 5'd0; pipe_wdata_i = 32'h555;
    check_eq("zero_prdy", 32'(pipe_ready_o), 32'd1);
    step();
    pipe_valid_i = 1'b0;
    check_wr("zero", 1'b0, 5'd12, 32'hB2);
    step();

    // Asynchronous reset in FORCE with two entries buffered
    pipe_valid_i = 1'b1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'h400;
    unit_valid_i = 1'b1; unit_waddr_i = 5'd13; unit_wdata_i = 32'hC0;
    step();
    unit_waddr_i = 5'd14; unit_wdata_i = 32'hC1;
    step();
    unit_valid_i = 1'b0;
    step(); step(); step();
    check_eq("ar_force_prdy", 32'(pipe_ready_o), 32'd0);
    check_wr("ar_before", 1'b1, 5'd7, 32'h400);
    #2;
    rst = 1'b0;
    #1;
    check_wr("ar_async", 1'b0, 5'd0, 32'h0);
    check_eq("ar_prdy", 32'(pipe_ready_o), 32'd0);
    check_eq("ar_urdy", 32'(unit_ready_o), 32'd0);
    pipe_valid_i = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_wr("ar_stale", 1'b0, 5'd0, 32'h0);
    end
    check_eq("ar_urdy_after", 32'(unit_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_wb_arbiter.md
CPU_WB_ARBITER -- requirements
Module: cpu_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning cycles a buffered unit result may wait before the pipeline is forced to yield.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the unit-result buffer depth (power of two, >=2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-006 pipe_valid_i  input  1  main-pipeline writeback request.
REQ-007 pipe_waddr_i  input  5  pipeline destination register (RegAddr_t).
REQ-008 pipe_wdata_i  input  32  pipeline write data (Word_t).
REQ-009 pipe_ready_o  output  1  pipeline request accepted this cycle.
REQ-010 unit_valid_i  input  1  long-latency unit (mul/div/load-miss) result valid.
REQ-011 unit_waddr_i  input  5  unit destination register.
REQ-012 unit_wdata_i  input  32  unit result data.
REQ-013 unit_ready_o  output  1  buffer can accept a unit result.
REQ-014 we_o  output  1  register-file write enable (Bit_t).
REQ-015 waddr_o  output  5  register-file write address.
REQ-016 wdata_o  output  32  register-file write data.

Function
REQ-017 SHALL own the single register-file write port and share it between pipeline and unit requesters, one write per cycle.
REQ-018 Unit results SHALL enter a FIFO_DEPTH-entry FIFO; push when unit_valid_i && unit_ready_o; unit_ready_o = !full, derived from registered count only.
REQ-019 FSM states NORMAL and FORCE; reset state NORMAL.
REQ-020 NORMAL: pipe_ready_o=1; grant pipeline if pipe_valid_i, else grant FIFO head if non-empty, else idle.
REQ-021 FORCE: pipe_ready_o=0; grant FIFO head (non-empty guaranteed); next state NORMAL.
REQ-022 Wait counter (width clog2(STARVE_LIMIT+1)) SHALL increment each cycle FIFO is non-empty and head not granted, saturating at STARVE_LIMIT; clear on any FIFO grant or when FIFO empty.
REQ-023 NORMAL->FORCE when counter reaches STARVE_LIMIT at clock edge; exactly one FIFO entry drained per FORCE visit.
REQ-024 Granted request SHALL appear on we_o/waddr_o/wdata_o at next rising edge (1-cycle registered latency); no grant -> we_o=0, waddr_o/wdata_o hold prior values.
REQ-025 Granted request with waddr==0 SHALL complete handshake/pop but drive we_o=0.
REQ-026 Simultaneous push and pop on full FIFO SHALL both succeed (count unchanged); push on empty FIFO not grantable same cycle (head valid next cycle).
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-028 No destination-ordering check; upstream scoreboard guarantees pipeline and buffered unit results never target the same nonzero register concurrently.
REQ-029 Pipeline request not accepted (pipe_ready_o=0) SHALL be held stable by the pipeline; arbiter drops nothing.

Reset
REQ-030 rst=0 SHALL immediately force we_o=0, waddr_o=0, wdata_o=0, FIFO empty, count=0, counter=0, state NORMAL.
REQ-031 During reset pipe_ready_o=0 and unit_ready_o=0; reset mid-operation discards all buffered results.
REQ-032 First grant possible on first rising edge after rst deasserts.

Verification
REQ-033 Pipeline only: pipe_valid_i=1, waddr=5, wdata=0xDEADBEEF -> next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF.
REQ-034 Idle pipeline: unit push waddr=3, data=0x12 -> granted cycle after push, we_o=1/waddr_o=3 one cycle later; unit_ready_o stays 1.
REQ-035 Starvation: pipe_valid_i held 1, one unit push -> pipeline granted 4 cycles, FORCE cycle with pipe_ready_o=0 writes unit result, NORMAL resumes next cycle.
REQ-036 Full FIFO: two pushes while pipeline busy -> unit_ready_o=0; simultaneous FORCE pop and push -> count stays 2, unit_ready_o remains 0.
REQ-037 Zero destination: pipeline waddr=0 -> pipe_ready_o=1, we_o stays 0.
REQ-038 Async reset with 2 entries buffered mid-FORCE -> outputs 0 without clock edge; after release no stale writes emitted.
